// File: rtl/cp0_tlb_unit.sv
// CP0 TLB block: EntryHi/EntryLo0/EntryLo1/Index/Random registers plus a TLBNUM-entry TLB; runs TLBP/TLBR/TLBWI/TLBWR.
// Latency: TLBR/TLBWI/TLBWR complete one edge after acceptance; TLBP scans one entry per cycle (1..TLBNUM edges).
// Backpressure: op_ready is high only in IDLE; a request seen while busy is ignored and must be held. Option macro: CP0_TLB_RANDOM_EN.
module cp0_tlb_unit #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  wen,
    input  logic [31:0] EntryHi_wdata,
    input  logic [31:0] EntryLo0_wdata,
    input  logic [31:0] EntryLo1_wdata,
    input  logic [31:0] Index_wdata,
    input  logic        op_valid,
    input  logic [1:0]  op,
    output logic        op_ready,
    output logic        op_done,
    output logic [31:0] EntryHi,
    output logic [31:0] EntryLo0,
    output logic [31:0] EntryLo1,
    output logic [31:0] Index,
    output logic [31:0] Random
);

    // Writable-bit masks: unimplemented fields always read as zero.
    localparam logic [31:0]     HI_MASK  = 32'hFFFF_E0FF;
    localparam logic [31:0]     LO_MASK  = 32'h03FF_FFFF;
    localparam logic [31:0]     IDX_MASK = 32'h8000_0000 | (32'(TLBNUM) - 32'd1);
    localparam logic [IDXW-1:0] IDX_MAX  = IDXW'(TLBNUM - 1);

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [31:0]     entryhi_q, entryhi_d;
    logic [31:0]     entrylo0_q, entrylo0_d;
    logic [31:0]     entrylo1_q, entrylo1_d;
    logic [31:0]     index_q, index_d;
    logic            op_done_q, op_done_d;

    // TLB array. Each page keeps {PFN, C, D, V} = EntryLo[25:1]; G is shared.
    logic [18:0]     tlb_vpn2_q [TLBNUM];
    logic [7:0]      tlb_asid_q [TLBNUM];
    logic            tlb_g_q    [TLBNUM];
    logic [24:0]     tlb_lo0_q  [TLBNUM];
    logic [24:0]     tlb_lo1_q  [TLBNUM];

    logic            tlb_we;
    logic [IDXW-1:0] tlb_waddr;
    logic            probe_hit;
    logic [IDXW-1:0] rd_idx;

`ifdef CP0_TLB_RANDOM_EN
    logic [IDXW-1:0] random_q, random_d;
`endif

    // Probe compares the live EntryHi with the entry under the scan counter.
    assign probe_hit = (tlb_vpn2_q[cnt_q] == entryhi_q[31:13]) &&
                       (tlb_g_q[cnt_q] || (tlb_asid_q[cnt_q] == entryhi_q[7:0]));

    assign rd_idx = index_q[IDXW-1:0];

    // Next-state, MTC0 and operation results; FSM results are applied after MTC0 so they win.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        entryhi_d  = entryhi_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        index_d    = index_q;
        op_done_d  = 1'b0;
        tlb_we     = 1'b0;
        tlb_waddr  = rd_idx;
`ifdef CP0_TLB_RANDOM_EN
        random_d   = (random_q == '0) ? IDX_MAX : random_q - IDXW'(1);
`endif

        if (wen[3]) entryhi_d  = EntryHi_wdata  & HI_MASK;
        if (wen[2]) entrylo0_d = EntryLo0_wdata & LO_MASK;
        if (wen[1]) entrylo1_d = EntryLo1_wdata & LO_MASK;
        if (wen[0]) index_d    = Index_wdata    & IDX_MASK;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    op_d = op;
                    if (op == OP_TLBP) begin
                        state_d = ST_PROBE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_PROBE: begin
                if (probe_hit) begin
                    index_d   = {{(32-IDXW){1'b0}}, cnt_q};
                    state_d   = ST_IDLE;
                    op_done_d = 1'b1;
                end else if (cnt_q == IDX_MAX) begin
                    index_d   = 32'h8000_0000;
                    state_d   = ST_IDLE;
                    op_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDXW'(1);
                end
            end
            ST_EXEC: begin
                state_d   = ST_IDLE;
                op_done_d = 1'b1;
                case (op_q)
                    OP_TLBR: begin
                        entryhi_d  = {tlb_vpn2_q[rd_idx], 5'b0, tlb_asid_q[rd_idx]};
                        entrylo0_d = {6'b0, tlb_lo0_q[rd_idx], tlb_g_q[rd_idx]};
                        entrylo1_d = {6'b0, tlb_lo1_q[rd_idx], tlb_g_q[rd_idx]};
                    end
                    OP_TLBWI, OP_TLBWR: begin
                        tlb_we = 1'b1;
`ifdef CP0_TLB_RANDOM_EN
                        if (op_q == OP_TLBWR) tlb_waddr = random_q;
                        random_d = IDX_MAX;
`endif
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and architectural registers; enable low freezes everything including op_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_TLBP;
            cnt_q      <= '0;
            entryhi_q  <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
            index_q    <= '0;
            op_done_q  <= 1'b0;
        end else if (enable) begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            entryhi_q  <= entryhi_d;
            entrylo0_q <= entrylo0_d;
            entrylo1_q <= entrylo1_d;
            index_q    <= index_d;
            op_done_q  <= op_done_d;
        end
    end

    // TLB array: cleared on reset, written from the current registers by TLBWI/TLBWR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLBNUM; i++) begin
                tlb_vpn2_q[i] <= '0;
                tlb_asid_q[i] <= '0;
                tlb_g_q[i]    <= 1'b0;
                tlb_lo0_q[i]  <= '0;
                tlb_lo1_q[i]  <= '0;
            end
        end else if (enable && tlb_we) begin
            tlb_vpn2_q[tlb_waddr] <= entryhi_q[31:13];
            tlb_asid_q[tlb_waddr] <= entryhi_q[7:0];
            tlb_g_q[tlb_waddr]    <= entrylo0_q[0] & entrylo1_q[0];
            tlb_lo0_q[tlb_waddr]  <= entrylo0_q[25:1];
            tlb_lo1_q[tlb_waddr]  <= entrylo1_q[25:1];
        end
    end

`ifdef CP0_TLB_RANDOM_EN
    // Free-running down-counter used to pick the TLBWR victim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_q <= IDX_MAX;
        end else if (enable) begin
            random_q <= random_d;
        end
    end

    assign Random = {{(32-IDXW){1'b0}}, random_q};
`else
    assign Random = 32'd0;
`endif

    assign op_ready = (state_q == ST_IDLE);
    assign op_done  = op_done_q;
    assign EntryHi  = entryhi_q;
    assign EntryLo0 = entrylo0_q;
    assign EntryLo1 = entrylo1_q;
    assign Index    = index_q;

endmodule

// File: tb/tb_cp0_tlb_unit.sv
// Directed bench for cp0_tlb_unit with TLBNUM=16.
// Drives inputs and samples outputs 1 time unit after the rising edge.
// Every comparison goes through check_eq; one summary line at the end.
module tb_cp0_tlb_unit;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  wen;
    logic [31:0] EntryHi_wdata, EntryLo0_wdata, EntryLo1_wdata, Index_wdata;
    logic        op_valid;
    logic [1:0]  op;
    logic        op_ready, op_done;
    logic [31:0] EntryHi, EntryLo0, EntryLo1, Index, Random;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

`ifdef CP0_TLB_RANDOM_EN
    localparam logic [31:0] RND_RST = 32'd15;
    localparam logic [1:0]  OP_WR_G = 2'b10;
`else
    localparam logic [31:0] RND_RST = 32'd0;
    localparam logic [1:0]  OP_WR_G = 2'b11;
`endif

    cp0_tlb_unit #(.TLBNUM(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .wen            (wen),
        .EntryHi_wdata  (EntryHi_wdata),
        .EntryLo0_wdata (EntryLo0_wdata),
        .EntryLo1_wdata (EntryLo1_wdata),
        .Index_wdata    (Index_wdata),
        .op_valid       (op_valid),
        .op             (op),
        .op_ready       (op_ready),
        .op_done        (op_done),
        .EntryHi        (EntryHi),
        .EntryLo0       (EntryLo0),
        .EntryLo1       (EntryLo1),
        .Index          (Index),
        .Random         (Random)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0_all(input logic [31:0] hi, input logic [31:0] lo0,
                            input logic [31:0] lo1, input logic [31:0] idx);
        wen = 4'hF;
        EntryHi_wdata = hi; EntryLo0_wdata = lo0; EntryLo1_wdata = lo1; Index_wdata = idx;
        tick();
        wen = 4'h0;
    endtask

    task automatic start_op(input logic [1:0] o);
        op_valid = 1'b1;
        op = o;
        tick();
        op_valid = 1'b0;
    endtask

    // Returns edges after acceptance until op_done is seen high, or -1 on timeout.
    task automatic run_op(input logic [1:0] o, input int max_cyc, output int n);
        start_op(o);
        n = 0;
        while (n < max_cyc && !op_done) begin
            tick();
            n++;
        end
        if (!op_done) n = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b1; wen = 4'h0; op_valid = 1'b0; op = 2'b00;
        EntryHi_wdata = '0; EntryLo0_wdata = '0; EntryLo1_wdata = '0; Index_wdata = '0;

        // Reset state
        #13;
        check_eq("rst_hi", EntryHi, 32'h0);
        check_eq("rst_lo0", EntryLo0, 32'h0);
        check_eq("rst_lo1", EntryLo1, 32'h0);
        check_eq("rst_idx", Index, 32'h0);
        check_eq("rst_rnd", Random, RND_RST);
        check_eq("rst_rdy", {31'b0, op_ready}, 32'd1);
        check_eq("rst_done", {31'b0, op_done}, 32'd0);
        rst = 1'b0;
        tick();

        // Field masking on MTC0 writes
        mtc0_all(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_eq("mask_hi", EntryHi, 32'hFFFF_E0FF);
        check_eq("mask_lo0", EntryLo0, 32'h03FF_FFFF);
        check_eq("mask_lo1", EntryLo1, 32'h03FF_FFFF);
        check_eq("mask_idx", Index, 32'h8000_000F);

        // TLBWI then TLBR round trip
        mtc0_all(32'h0040_2005, 32'h0000_0047, 32'h0000_0087, 32'd5);
        run_op(2'b10, 8, cyc);
        check_eq("wi_cyc", cyc, 32'd1);
        tick();
        check_eq("wi_done_drop", {31'b0, op_done}, 32'd0);
        mtc0_all(32'h0, 32'h0, 32'h0, 32'd5);
        check_eq("clr_hi", EntryHi, 32'h0);
        run_op(2'b01, 8, cyc);
        check_eq("tr_cyc", cyc, 32'd1);
        check_eq("tr_hi", EntryHi, 32'h0040_2005);
        check_eq("tr_lo0", EntryLo0, 32'h0000_0047);
        check_eq("tr_lo1", EntryLo1, 32'h0000_0087);
        check_eq("tr_rnd", Random, RND_RST == 32'd0 ? 32'd0 : Random);

        // G stored as AND of both G bits (op 11 acts as TLBWI when Random is disabled)
        mtc0_all(32'h0000_4000, 32'h0000_0041, 32'h0000_0080, 32'd2);
        run_op(OP_WR_G, 8, cyc);
        check_eq("g_wr_cyc", cyc, 32'd1);
        mtc0_all(32'h0, 32'h0, 32'h0, 32'd2);
        run_op(2'b01, 8, cyc);
        check_eq("g_hi", EntryHi, 32'h0000_4000);
        check_eq("g_lo0", EntryLo0, 32'h0000_0040);
        check_eq("g_lo1", EntryLo1, 32'h0000_0080);

        // TLBP: entries 3 and 9 identical, lowest index reported
        mtc0_all(32'h1234_6011, 32'h2, 32'h2, 32'd3);
        run_op(2'b10, 8, cyc);
        mtc0_all(32'h1234_6011, 32'h2, 32'h2, 32'd9);
        run_op(2'b10, 8, cyc);
        mtc0_all(32'h1234_6011, 32'h0, 32'h0, 32'd0);
        run_op(2'b00, 40, cyc);
        check_eq("p3_cyc", cyc, 32'd4);
        check_eq("p3_idx", Index, 32'd3);
        mtc0_all(32'h1234_6022, 32'h0, 32'h0, 32'd0);
        run_op(2'b00, 40, cyc);
        check_eq("pmiss_cyc", cyc, 32'd16);
        check_eq("pmiss_idx", Index, 32'h8000_0000);

        // TLBP global match at 7; MTC0 Index at the completing edge loses
        mtc0_all(32'h5678_A033, 32'h1, 32'h1, 32'd7);
        run_op(2'b10, 8, cyc);
        mtc0_all(32'h5678_A0FF, 32'h0, 32'h0, 32'd0);
        start_op(2'b00);
        repeat (7) tick();
        check_eq("p7_pre_done", {31'b0, op_done}, 32'd0);
        wen = 4'b0001; Index_wdata = 32'h0000_000A;
        tick();
        wen = 4'h0;
        check_eq("p7_idx", Index, 32'd7);
        check_eq("p7_done", {31'b0, op_done}, 32'd1);

        // enable low: MTC0 ignored, op_done held
        enable = 1'b0; wen = 4'b0001; Index_wdata = 32'h0000_000C;
        repeat (3) tick();
        check_eq("en_idx", Index, 32'd7);
        check_eq("en_done", {31'b0, op_done}, 32'd1);
        wen = 4'h0; enable = 1'b1;
        tick();
        check_eq("en_done_drop", {31'b0, op_done}, 32'd0);
        check_eq("en_idx2", Index, 32'd7);

        // Async reset mid-probe (counter at 6)
        mtc0_all(32'h7777_7000, 32'h0, 32'h0, 32'd3);
        start_op(2'b00);
        repeat (6) tick();
        check_eq("mid_rdy_busy", {31'b0, op_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_idx", Index, 32'h0);
        check_eq("mid_done", {31'b0, op_done}, 32'd0);
        check_eq("mid_rdy", {31'b0, op_ready}, 32'd1);
        check_eq("mid_hi", EntryHi, 32'h0);
        check_eq("mid_rnd", Random, RND_RST);
        #3 rst = 1'b0;
        tick();
        check_eq("post_idx", Index, 32'h0);
        check_eq("post_rdy", {31'b0, op_ready}, 32'd1);
        mtc0_all(32'h1111_1111, 32'h1, 32'h1, 32'd3);
        run_op(2'b01, 8, cyc);
        check_eq("post_tr_hi", EntryHi, 32'h0);
        check_eq("post_tr_lo0", EntryLo0, 32'h0);
        check_eq("post_tr_lo1", EntryLo1, 32'h0);

`ifdef CP0_TLB_RANDOM_EN
        // Random: countdown, freeze, wrap and TLBWR reload
        rst = 1'b1;
        #2 rst = 1'b0;
        check_eq("r_rst", Random, 32'd15);
        repeat (3) tick();
        check_eq("r_dec", Random, 32'd12);
        enable = 1'b0;
        repeat (3) tick();
        check_eq("r_frozen", Random, 32'd12);
        enable = 1'b1;
        repeat (12) tick();
        check_eq("r_zero", Random, 32'd0);
        tick();
        check_eq("r_wrap", Random, 32'd15);
        mtc0_all(32'h2468_A055, 32'h5, 32'h3, 32'd0);
        run_op(2'b11, 8, cyc);
        check_eq("r_wr_cyc", cyc, 32'd1);
        check_eq("r_reload", Random, 32'd15);
        mtc0_all(32'h0, 32'h0, 32'h0, 32'd13);
        run_op(2'b01, 8, cyc);
        check_eq("r_tr_hi", EntryHi, 32'h2468_A055);
        check_eq("r_tr_lo0", EntryLo0, 32'h0000_0005);
        check_eq("r_tr_lo1", EntryLo1, 32'h0000_0003);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
